// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, states, ALU codes and mux selects.
// CTRL_JUMP_LINK_EN adds JR/JAL to the set of recognised jumps; without it they decode as NOPs.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LS,
        CLS_BR,
        CLS_JUMP,
        CLS_NOP
    } op_class_e;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_RS  = 2'b10;
    localparam logic [1:0] PCSRC_JMP = 2'b11;

    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

    function automatic op_class_e op_class(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND,
            OP_ANDI, OP_ORI, OP_SLL, OP_SLTI: return CLS_ALU;
            OP_LW, OP_SW:                     return CLS_LS;
            OP_BEQ, OP_BNE, OP_BLTZ:          return CLS_BR;
            OP_J:                             return CLS_JUMP;
`ifdef CTRL_JUMP_LINK_EN
            OP_JR, OP_JAL:                    return CLS_JUMP;
`endif
            default:                          return CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational output decode for control_fsm: enables and mux selects from state, opcode and ALU flags.
// JR/JAL decode depends on CTRL_JUMP_LINK_EN through ctrl_pkg::op_class.
module ctrl_outdec
    import ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       rst_n_i,
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       sign_i,
    output logic       pc_wre_o,
    output logic       ir_wre_o,
    output logic       reg_wre_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       alu_src_a_o,
    output logic       alu_src_b_o,
    output logic       ext_sel_o,
    output logic       db_data_src_o,
    output logic       wr_reg_d_src_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] pc_src_o,
    output logic [2:0] alu_op_o
);

    logic is_rtype;
    logic is_imm_alu;
    logic br_taken;

    assign is_rtype   = (opcode_i == OP_ADD) || (opcode_i == OP_SUB) ||
                        (opcode_i == OP_AND) || (opcode_i == OP_SLL);
    assign is_imm_alu = (opcode_i == OP_ADDIU) || (opcode_i == OP_ANDI) ||
                        (opcode_i == OP_ORI)   || (opcode_i == OP_SLTI);
    assign br_taken   = ((opcode_i == OP_BEQ)  &&  zero_i) ||
                        ((opcode_i == OP_BNE)  && !zero_i) ||
                        ((opcode_i == OP_BLTZ) &&  sign_i);

    always_comb begin
        pc_wre_o       = 1'b0;
        ir_wre_o       = 1'b0;
        reg_wre_o      = 1'b0;
        mem_rd_o       = 1'b0;
        mem_wr_o       = 1'b0;
        pc_src_o       = PCSRC_SEQ;
        // Datapath selects follow the opcode in every state so they never float.
        alu_src_a_o    = (opcode_i == OP_SLL);
        alu_src_b_o    = is_imm_alu || (opcode_i == OP_LW) || (opcode_i == OP_SW);
        ext_sel_o      = !((opcode_i == OP_ANDI) || (opcode_i == OP_ORI));
        db_data_src_o  = (opcode_i == OP_LW);
        wr_reg_d_src_o = 1'b1;
        reg_dst_o      = is_rtype ? REGDST_RD : REGDST_RT;
        case (opcode_i)
            OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: alu_op_o = ALU_SUB;
            OP_AND, OP_ANDI:                 alu_op_o = ALU_AND;
            OP_ORI:                          alu_op_o = ALU_OR;
            OP_SLL:                          alu_op_o = ALU_SLL;
            OP_SLTI:                         alu_op_o = ALU_SLT;
            default:                         alu_op_o = ALU_ADD;
        endcase

        case (state_i)
            S_IF: ir_wre_o = 1'b1;
            S_ID: begin
                if (opcode_i != HALT_OP) begin
                    case (op_class(opcode_i))
                        CLS_JUMP: begin
                            pc_wre_o = 1'b1;
                            pc_src_o = (opcode_i == OP_JR) ? PCSRC_RS : PCSRC_JMP;
                            if (opcode_i == OP_JAL) begin
                                reg_wre_o      = 1'b1;
                                reg_dst_o      = REGDST_RA;
                                wr_reg_d_src_o = 1'b0;
                            end
                        end
                        CLS_NOP: pc_wre_o = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_WB_AL, S_WB_LD: begin
                reg_wre_o = 1'b1;
                pc_wre_o  = 1'b1;
            end
            S_MEM: begin
                mem_rd_o = (opcode_i == OP_LW);
                mem_wr_o = (opcode_i == OP_SW);
                pc_wre_o = (opcode_i == OP_SW);
            end
            S_EXE_BR: begin
                pc_wre_o = 1'b1;
                pc_src_o = br_taken ? PCSRC_BR : PCSRC_SEQ;
            end
            default: ;
        endcase

        // While reset is held nothing may be written and every select sits at 0.
        if (!rst_n_i) begin
            pc_wre_o       = 1'b0;
            ir_wre_o       = 1'b0;
            reg_wre_o      = 1'b0;
            mem_rd_o       = 1'b0;
            mem_wr_o       = 1'b0;
            alu_src_a_o    = 1'b0;
            alu_src_b_o    = 1'b0;
            ext_sel_o      = 1'b0;
            db_data_src_o  = 1'b0;
            wr_reg_d_src_o = 1'b0;
            reg_dst_o      = 2'b00;
            pc_src_o       = 2'b00;
            alu_op_o       = 3'b000;
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle CPU control FSM: state register and next-state logic; outputs decoded in ctrl_outdec.
// Define CTRL_JUMP_LINK_EN to enable JR/JAL; otherwise they execute as NOPs.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic       DBDataSrc,
    output logic       WrRegDSrc,
    output logic [1:0] RegDst,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                // A halt parks the FSM in ID until reset.
                if (opcode == HALT_OP) begin
                    state_d = S_ID;
                end else begin
                    case (op_class(opcode))
                        CLS_ALU: state_d = S_EXE_AL;
                        CLS_LS:  state_d = S_EXE_LS;
                        CLS_BR:  state_d = S_EXE_BR;
                        default: state_d = S_IF;
                    endcase
                end
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
        endcase
    end

    assign state = state_q;

    ctrl_outdec #(
        .HALT_OP (HALT_OP)
    ) u_outdec (
        .rst_n_i        (RST_N),
        .state_i        (state_q),
        .opcode_i       (opcode),
        .zero_i         (zero),
        .sign_i         (sign),
        .pc_wre_o       (PCWre),
        .ir_wre_o       (IRWre),
        .reg_wre_o      (RegWre),
        .mem_rd_o       (mRD),
        .mem_wr_o       (mWR),
        .alu_src_a_o    (ALUSrcA),
        .alu_src_b_o    (ALUSrcB),
        .ext_sel_o      (ExtSel),
        .db_data_src_o  (DBDataSrc),
        .wr_reg_d_src_o (WrRegDSrc),
        .reg_dst_o      (RegDst),
        .pc_src_o       (PCSrc),
        .alu_op_o       (ALUOp)
    );

endmodule
